// File: rtl/shift_ser_pkg.sv
// Shared types for the parallel-to-serial transmit controller.
package shift_ser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int IDX_W_DEF = 3;

   // bit_idx width for a given word length (WIDTH >= 2)
   function automatic int idx_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/shift_reg_core.sv
// WIDTH-bit load/shift register; o_tap_nxt is the bit at the transmit head after this edge.
module shift_reg_core
   import shift_ser_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_shift_en,
   input  logic             i_dir,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_tap_nxt
);

   logic [WIDTH-1:0] r_sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr <= '0;
      end else if (i_load) begin
         r_sr <= i_data;
      end else if (i_shift_en) begin
         r_sr <= i_dir ? {1'b0, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], 1'b0};
      end
   end

   // i_dir=1 sends LSB first, so the head is bit 0 and the register moves right
   assign o_tap_nxt = i_load ? (i_dir ? i_data[0] : i_data[WIDTH-1])
                             : (i_dir ? r_sr[1]   : r_sr[WIDTH-2]);

endmodule

// File: rtl/shift_ser_ctrl.sv
// Parallel-to-serial transmitter: valid/ready word intake, WIDTH-cycle frame, programmable idle gap.
module shift_ser_ctrl
   import shift_ser_pkg::*;
#(
   parameter int   WIDTH    = 8,
   parameter int   GAP_W    = 4,
   parameter logic IDLE_LVL = 1'b0,
   localparam int  IW       = idx_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   input  logic             lsb_first,
   input  logic [GAP_W-1:0] gap_len,
   output logic             ser_out,
   output logic             ser_en,
   output logic [IW-1:0]    bit_idx,
   output logic             busy,
   output logic             done
);

   state_t           r_state, w_state_nxt;
   logic             r_live;
   logic             r_lsb;
   logic             r_ser_out;
   logic [GAP_W-1:0] r_gap_len;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [IW-1:0]    r_bit_idx;

   logic w_last, w_accept, w_shift_en, w_dir, w_tap_nxt;

   assign w_last     = (r_state == SHIFT) && (r_bit_idx == IW'(WIDTH - 1));
   // r_live keeps s_ready low until the first edge after reset release
   assign s_ready    = r_live && ((r_state == IDLE) || (w_last && (r_gap_len == '0)));
   assign w_accept   = s_valid && s_ready;
   assign w_shift_en = (r_state == SHIFT) && !w_last;
   assign w_dir      = w_accept ? lsb_first : r_lsb;

   shift_reg_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept),
      .i_shift_en (w_shift_en),
      .i_dir      (w_dir),
      .i_data     (s_data),
      .o_tap_nxt  (w_tap_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = SHIFT;
         SHIFT: begin
            if (w_last) begin
               if (w_accept)               w_state_nxt = SHIFT;
               else if (r_gap_len == '0)   w_state_nxt = IDLE;
               else                        w_state_nxt = GAP;
            end
         end
         GAP:     if (r_gap_cnt == GAP_W'(1)) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live    <= 1'b0;
         r_lsb     <= 1'b0;
         r_gap_len <= '0;
         r_gap_cnt <= '0;
         r_bit_idx <= '0;
         r_ser_out <= IDLE_LVL;
      end else begin
         r_live <= 1'b1;
         if (w_accept) begin
            r_lsb     <= lsb_first;
            r_gap_len <= gap_len;
         end
         // staying in SHIFT without a fresh accept means the frame continues
         r_bit_idx <= ((w_state_nxt == SHIFT) && !w_accept) ? r_bit_idx + IW'(1) : '0;
         if (w_last)
            r_gap_cnt <= r_gap_len;
         else if (r_state == GAP)
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
         r_ser_out <= (w_state_nxt == SHIFT) ? w_tap_nxt : IDLE_LVL;
      end
   end

   assign ser_out = r_ser_out;
   assign ser_en  = (r_state == SHIFT);
   assign bit_idx = r_bit_idx;
   assign busy    = (r_state != IDLE);
   assign done    = w_last;

endmodule
